// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the key debouncer (see key_debounce.sv for
// the optional DEBOUNCE_PULSE_OUT_EN pulse outputs).
package key_debounce_pkg;

  localparam int unsigned DEFAULT_CNT_W   = 20;
  localparam int unsigned DEFAULT_CNT_MAX = 999_999;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_e;

  function automatic logic is_wait(state_e st);
    return (st == WAIT_HIGH) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/key_debounce_sync.sv
// Two-flop synchroniser for the raw key level; both flops clear to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Key/switch debouncer: synchronise, then qualify each level change for CNT_MAX+1
// stable cycles. Define DEBOUNCE_PULSE_OUT_EN to add press/release pulse outputs.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned CNT_W   = DEFAULT_CNT_W,
  parameter int unsigned CNT_MAX = DEFAULT_CNT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic data_out,
  output logic busy
`ifdef DEBOUNCE_PULSE_OUT_EN
  ,
  output logic press_pulse,
  output logic release_pulse
`endif
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(CNT_MAX);

  logic             s_sync;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_out_q, data_out_d;
  logic             busy_q, busy_d;
`ifdef DEBOUNCE_PULSE_OUT_EN
  logic             press_q, press_d;
  logic             release_q, release_d;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (data_in),
    .q     (s_sync)
  );

  // Any opposite-level sample during a WAIT state drops back to the stable state,
  // so the next attempt always starts again from cnt = 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
`ifdef DEBOUNCE_PULSE_OUT_EN
    press_d    = 1'b0;
    release_d  = 1'b0;
`endif
    case (state_q)
      STABLE_LOW: begin
        if (s_sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s_sync) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d    = STABLE_HIGH;
          data_out_d = 1'b1;
          cnt_d      = '0;
`ifdef DEBOUNCE_PULSE_OUT_EN
          press_d    = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s_sync) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s_sync) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d    = STABLE_LOW;
          data_out_d = 1'b0;
          cnt_d      = '0;
`ifdef DEBOUNCE_PULSE_OUT_EN
          release_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
    busy_d = is_wait(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STABLE_LOW;
      cnt_q      <= '0;
      data_out_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef DEBOUNCE_PULSE_OUT_EN
      press_q    <= 1'b0;
      release_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
`ifdef DEBOUNCE_PULSE_OUT_EN
      press_q    <= press_d;
      release_q  <= release_d;
`endif
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
`ifdef DEBOUNCE_PULSE_OUT_EN
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
`endif

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter CNT_W, default 20, bit width of the stability counter.
REQ-002 Parameter CNT_MAX, default 999_999 (20 ms at 50 MHz), cycles the synchronised input must hold before the output follows; SHALL fit in CNT_W bits and be >= 1.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 data_in  input  1  raw, asynchronous, bouncing key or switch level.
REQ-006 data_out  output  1  registered debounced level; feeds the edge-detect stage.
REQ-007 busy  output  1  registered; high while a candidate transition is being qualified.
REQ-008 press_pulse  output  1  one-cycle pulse on a qualified 0->1 change; present only with DEBOUNCE_PULSE_OUT_EN.
REQ-009 release_pulse  output  1  one-cycle pulse on a qualified 1->0 change; present only with DEBOUNCE_PULSE_OUT_EN.

Function
REQ-010 data_in SHALL pass through a 2-flop synchroniser; s denotes the second flop's output; the first flop SHALL be the only logic reading data_in.
REQ-011 The FSM SHALL have four states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-012 STABLE_LOW: s=1 -> WAIT_HIGH, cnt<=0; otherwise stay.
REQ-013 WAIT_HIGH: s=0 -> STABLE_LOW, cnt<=0 (bounce rejected, data_out unchanged); s=1 and cnt==CNT_MAX -> STABLE_HIGH, data_out<=1, cnt<=0; otherwise cnt<=cnt+1.
REQ-014 STABLE_HIGH and WAIT_LOW SHALL mirror REQ-012/013 with polarity inverted; data_out<=0 on qualification.
REQ-015 Latency: for a clean step on data_in first sampled at edge 1, data_out SHALL change at edge CNT_MAX+4.
REQ-016 Any opposite-level sample of s during a WAIT state SHALL restart qualification from cnt=0 on the next return to that WAIT state.
REQ-017 busy SHALL be 1 exactly in the cycles the FSM is in WAIT_HIGH or WAIT_LOW.
REQ-018 cnt SHALL never exceed CNT_MAX and SHALL not wrap.
REQ-019 data_out SHALL change only at a qualification edge; never two changes less than CNT_MAX+1 cycles apart.

Reset
REQ-020 rst_n low SHALL asynchronously force both synchroniser flops 0, state STABLE_LOW, cnt 0, data_out 0, busy 0, press_pulse 0, release_pulse 0.
REQ-021 Reset asserted mid-qualification SHALL abandon it; after release, a held-high input SHALL requalify in full (REQ-015 latency from the first post-reset edge).

Configuration
REQ-022 With DEBOUNCE_PULSE_OUT_EN defined, press_pulse/release_pulse SHALL be registered high for exactly the one cycle following the edge at which data_out rises/falls.
REQ-023 Without DEBOUNCE_PULSE_OUT_EN, those ports and their registers SHALL not exist; all other behaviour identical.

Structure
REQ-024 Package key_debounce_pkg SHALL hold the 2-bit state typedef/encodings and the default CNT_W/CNT_MAX constants.
REQ-025 The synchroniser SHALL be a separate sub-module sync_2ff (clk, rst_n, d, q), reset value 0.

Verification (CNT_MAX=15, CNT_W=4)
REQ-026 Reset, then data_in 0->1 held -> data_out=0 through edge 18, 1 at edge 19; busy high edges 3..18.
REQ-027 data_in high 6 cycles, low 2, high held -> no data_out change during bounce; rises CNT_MAX+1 edges after the FSM last re-enters WAIT_HIGH.
REQ-028 data_in high 10 cycles, then low -> data_out stays 0, busy returns 0, FSM back in STABLE_LOW.
REQ-029 From data_out=1, data_in low held -> data_out falls at edge 19 after change; with DEBOUNCE_PULSE_OUT_EN release_pulse high exactly one cycle, press_pulse 0.
REQ-030 Assert rst_n low at cnt=10 in WAIT_HIGH, release with data_in still 1 -> all outputs 0 at reset, data_out rises at edge 19 after release.
REQ-031 Random bounce bursts shorter than 15 cycles for 10,000 cycles -> data_out never toggles; cnt never >15.
